// File: rtl/cla_multibyte_sequencer.sv
// cla_multibyte_sequencer: streams NBYTES-wide operands byte-serially through one 8-bit CLA slice.
// Optional subtract support is enabled with the CLA_SEQ_SUB_EN macro.
`default_nettype none

module CarryLookAheadAdder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] w_g;
   logic [7:0] w_p;
   logic [8:0] w_c;
   logic       w_run;
   logic       w_acc;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Each carry is the flat lookahead sum-of-products over all lower generate/propagate terms.
   always_comb begin
      w_c    = '0;
      w_run  = 1'b1;
      w_acc  = 1'b0;
      w_c[0] = cin;
      for (int i = 0; i < 8; i++) begin
         w_run = 1'b1;
         w_acc = 1'b0;
         for (int j = i; j >= 0; j--) begin
            w_acc = w_acc | (w_run & w_g[j]);
            w_run = w_run & w_p[j];
         end
         w_c[i+1] = w_acc | (w_run & cin);
      end
   end

   assign sum  = w_p ^ w_c[7:0];
   assign cout = w_c[8];
endmodule

module cla_multibyte_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_a,
   input  logic [8*NBYTES-1:0]   in_b,
   input  logic                  in_cin,
`ifdef CLA_SEQ_SUB_EN
   input  logic                  in_sub,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_sum,
   output logic                  out_cout,
   output logic                  out_ovf
);
   localparam int c_W  = 8 * NBYTES;
   localparam int c_CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [c_W-1:0]  r_a;
   logic [c_W-1:0]  r_b;
   logic [c_W-1:0]  r_sum;
   logic            r_carry;
   logic [c_CW-1:0] r_cnt;
   logic            r_cout;
   logic            r_ovf;

   logic [c_W-1:0]  w_b_lat;
   logic            w_cin_lat;
   logic [7:0]      w_sum8;
   logic            w_cout8;
   logic            w_last;
   logic [c_W+7:0]  w_shift;

`ifdef CLA_SEQ_SUB_EN
   assign w_b_lat   = in_sub ? ~in_b : in_b;
   assign w_cin_lat = in_sub ? 1'b1  : in_cin;
`else
   assign w_b_lat   = in_b;
   assign w_cin_lat = in_cin;
`endif

   CarryLookAheadAdder u_cla (
      .a    (r_a[7:0]),
      .b    (r_b[7:0]),
      .cin  (r_carry),
      .sum  (w_sum8),
      .cout (w_cout8)
   );

   assign w_last  = (r_cnt == c_LAST);
   // New byte enters at the top so byte k ends up at out_sum[8k+7:8k] after NBYTES shifts.
   assign w_shift = {w_sum8, r_sum};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_next = S_ADD;
         S_ADD:   if (w_last)    w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default:                w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= w_b_lat;
                  r_carry <= w_cin_lat;
                  r_cnt   <= '0;
               end
            end
            S_ADD: begin
               r_a     <= r_a >> 8;
               r_b     <= r_b >> 8;
               r_sum   <= w_shift[c_W+7:8];
               r_carry <= w_cout8;
               r_cnt   <= r_cnt + c_CW'(1);
               if (w_last) begin
                  r_cout <= w_cout8;
                  r_ovf  <= (r_a[7] ~^ r_b[7]) & (w_sum8[7] ^ r_a[7]);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE) & ~rst;
   assign out_valid = (r_state == S_DONE);
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;
endmodule

`default_nettype wire
